// File: rtl/motoro3_pkg.sv
// motoro3_pkg: shared types and defaults for the motor PWM ramp controller.
// All ramp logic runs on the 10 MHz PWM clock, so M3_MIN_LEN (0x020) is 3.2 us of on-time.
package motoro3_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRamp     = 3'd1,
    StRun      = 3'd2,
    StStopping = 3'd3,
    StFault    = 3'd4
  } m3_state_e;

  localparam logic [11:0] M3_STEP         = 12'h008;
  localparam logic [11:0] M3_MIN_LEN      = 12'h020;
  localparam logic [11:0] M3_MAX_LEN      = 12'h1FF;
  localparam logic [7:0]  M3_HOLD_PERIODS = 8'd4;

  // Clamp a requested duty into [lo, hi].
  function automatic logic [11:0] m3_clamp(input logic [11:0] v, input logic [11:0] lo,
                                           input logic [11:0] hi);
    logic [11:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/motoro3_sat_step.sv
// motoro3_sat_step: one saturating ramp step.
//   len_i    current duty
//   tgt_i    ceiling when stepping up
//   step_i   step size
//   floor_i  floor when stepping down
//   dir_up_i 1 = step up toward tgt_i, 0 = step down toward floor_i
//   len_o    next duty, never past the ceiling/floor and never wrapped
module motoro3_sat_step (
  input  logic [11:0] len_i,
  input  logic [11:0] tgt_i,
  input  logic [11:0] step_i,
  input  logic [11:0] floor_i,
  input  logic        dir_up_i,
  output logic [11:0] len_o
);

  logic [12:0] sum;
  logic [12:0] diff;

  always_comb begin
    sum   = {1'b0, len_i} + {1'b0, step_i};
    diff  = {1'b0, len_i} - {1'b0, step_i};
    len_o = len_i;
    if (dir_up_i) begin
      len_o = sum[12] ? 12'hFFF : sum[11:0];
      if (len_o > tgt_i) len_o = tgt_i;
    end else begin
      // diff[12] set means the subtraction borrowed
      if (diff[12] || (diff[11:0] < floor_i)) len_o = floor_i;
      else                                    len_o = diff[11:0];
    end
  end

endmodule

// File: rtl/motoro3_pwm_ramp_ctrl.sv
// motoro3_pwm_ramp_ctrl: soft-start / soft-stop duty scheduler for the 3-phase PWM generator.
//   clk, nRst         10 MHz clock, async active-low reset
//   m3cntLast1        one-cycle PWM period-boundary tick
//   cmdStart/cmdStop  run / ramp-down requests (levels); cmdClear leaves FAULT (pulse)
//   cmdTarget         requested duty, clamped to [MIN_LEN, MAX_LEN] on each tick
//   faultIn           overcurrent / driver fault, forces PWM off on the next edge
//   m3r_pwmLenWant    duty to the generator; m3r_pwmMinMask constant MIN_LEN
//   pwmEnable         MOS driver gate; state FSM state; atTarget duty == target in RUN
module motoro3_pwm_ramp_ctrl
  import motoro3_pkg::*;
#(
  parameter logic [11:0] STEP         = M3_STEP,
  parameter logic [11:0] MIN_LEN      = M3_MIN_LEN,
  parameter logic [11:0] MAX_LEN      = M3_MAX_LEN,
  parameter logic [7:0]  HOLD_PERIODS = M3_HOLD_PERIODS
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        m3cntLast1,
  input  logic        cmdStart,
  input  logic        cmdStop,
  input  logic        cmdClear,
  input  logic [11:0] cmdTarget,
  input  logic        faultIn,
  output logic [11:0] m3r_pwmLenWant,
  output logic [11:0] m3r_pwmMinMask,
  output logic        pwmEnable,
  output logic [2:0]  state,
  output logic        atTarget
);

  m3_state_e   state_q, state_d;
  logic [11:0] len_q, len_d;
  logic        en_q, en_d;
  logic [11:0] tgt_q, tgt_d;
  logic [7:0]  hc_q, hc_d;
  logic [11:0] mask_q;
  logic        step_now;
  logic        step_up;
  logic [11:0] step_floor;
  logic [11:0] step_len;

  assign step_now   = m3cntLast1 && (hc_q == HOLD_PERIODS - 8'd1);
  assign step_up    = (state_q == StRamp) && (len_q < tgt_q);
  // RAMP saturates at the target; STOPPING saturates at the minimum on-time.
  assign step_floor = (state_q == StStopping) ? MIN_LEN : tgt_q;

  motoro3_sat_step u_sat_step (
    .len_i   (len_q),
    .tgt_i   (tgt_q),
    .step_i  (STEP),
    .floor_i (step_floor),
    .dir_up_i(step_up),
    .len_o   (step_len)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    en_d    = en_q;
    tgt_d   = m3cntLast1 ? m3_clamp(cmdTarget, MIN_LEN, MAX_LEN) : tgt_q;

    if (faultIn) begin
      state_d = StFault;
      len_d   = '0;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          len_d = '0;
          en_d  = 1'b0;
          if (m3cntLast1 && cmdStart && !cmdStop) begin
            state_d = StRamp;
            len_d   = MIN_LEN;
            en_d    = 1'b1;
          end
        end
        StRamp: begin
          if (cmdStop) begin
            state_d = StStopping;
          end else begin
            if (step_now && (len_q != tgt_q)) len_d = step_len;
            if (len_d == tgt_q) state_d = StRun;
          end
        end
        StRun: begin
          if (cmdStop)                             state_d = StStopping;
          else if (m3cntLast1 && (tgt_d != len_q)) state_d = StRamp;
        end
        StStopping: begin
          // The tick after reaching MIN_LEN shuts the drivers off.
          if (m3cntLast1 && (len_q == MIN_LEN)) begin
            state_d = StIdle;
            len_d   = '0;
            en_d    = 1'b0;
          end else if (step_now) begin
            len_d = step_len;
          end
        end
        StFault: begin
          len_d = '0;
          en_d  = 1'b0;
          if (cmdClear) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          len_d   = '0;
          en_d    = 1'b0;
        end
      endcase
    end

    // Any state change restarts the hold interval.
    if (state_d != state_q)            hc_d = '0;
    else if (step_now)                 hc_d = '0;
    else if (m3cntLast1)               hc_d = hc_q + 8'd1;
    else                               hc_d = hc_q;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= StIdle;
      len_q   <= '0;
      en_q    <= 1'b0;
      tgt_q   <= MIN_LEN;
      hc_q    <= '0;
      mask_q  <= MIN_LEN;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      en_q    <= en_d;
      tgt_q   <= tgt_d;
      hc_q    <= hc_d;
      mask_q  <= MIN_LEN;
    end
  end

  assign m3r_pwmLenWant = len_q;
  assign m3r_pwmMinMask = mask_q;
  assign pwmEnable      = en_q;
  assign state          = state_q;
  assign atTarget       = (state_q == StRun) && (len_q == tgt_q);

endmodule

// File: tb/tb_motoro3_pwm_ramp_ctrl.sv
// Scoreboard bench for motoro3_pwm_ramp_ctrl: the stimulus pushes every expected output
// change; a monitor pops one entry each time the DUT's outputs change.
module tb_motoro3_pwm_ramp_ctrl;

  localparam int GAP = 8;  // clocks between period ticks

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clr = 1'b0;
  logic        fault = 1'b0;
  logic [11:0] tgt_cmd = 12'h000;

  logic [11:0] dut_len;
  logic [11:0] dut_mask;
  logic        dut_en;
  logic [2:0]  dut_state;
  logic        dut_at;

  motoro3_pwm_ramp_ctrl dut (
    .clk           (clk),
    .nRst          (nRst),
    .m3cntLast1    (tick),
    .cmdStart      (start),
    .cmdStop       (stop),
    .cmdClear      (clr),
    .cmdTarget     (tgt_cmd),
    .faultIn       (fault),
    .m3r_pwmLenWant(dut_len),
    .m3r_pwmMinMask(dut_mask),
    .pwmEnable     (dut_en),
    .state         (dut_state),
    .atTarget      (dut_at)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] len;
    logic        en;
    logic [2:0]  st;
    logic        at;
  } exp_t;

  exp_t exp_q[$];
  exp_t last = '1;  // state 7 never occurs, so the first sample always counts
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ev  = 0;

  // Monitor: every output change consumes one expected entry.
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = {dut_len, dut_en, dut_state, dut_at};
    if (cur !== last) begin
      last = cur;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change got len=%h en=%b st=%0d at=%b (none expected)",
                 dut_len, dut_en, dut_state, dut_at);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          n_bad++;
          $display("FAIL ev%0d got len=%h en=%b st=%0d at=%b want len=%h en=%b st=%0d at=%b",
                   n_ev, dut_len, dut_en, dut_state, dut_at, e.len, e.en, e.st, e.at);
        end
      end
      n_ev++;
      n_cmp++;
      if (dut_mask !== 12'h020) begin
        n_bad++;
        $display("FAIL minmask got %h want 020", dut_mask);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired with %0d events pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [11:0] l, input logic e, input logic [2:0] s, input logic a);
    exp_q.push_back({l, e, s, a});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // One period tick; returns at posedge+1.
  task automatic do_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (GAP - 2) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  // Expected step sequence of a ramp already in RAMP; one step per 4 ticks.
  task automatic ramp_steps(input logic [11:0] from, input logic [11:0] to);
    logic [11:0] l;
    int          n;
    l = from;
    n = 0;
    while (l != to) begin
      if (l < to) l = ((to - l) > 12'd8) ? l + 12'd8 : to;
      else        l = ((l - to) > 12'd8) ? l - 12'd8 : to;
      n++;
      push(l, 1'b1, (l == to) ? 3'd2 : 3'd1, l == to);
    end
    ticks(4 * n);
  endtask

  task automatic retarget(input logic [11:0] cmd, input logic [11:0] from, input logic [11:0] to);
    tgt_cmd = cmd;
    push(from, 1'b1, 3'd1, 1'b0);
    do_tick();
    ramp_steps(from, to);
  endtask

  initial begin
    push(12'h000, 1'b0, 3'd0, 1'b0);
    #1 nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;

    // Soft start 0x20 -> 0x60
    tgt_cmd = 12'h060;
    start   = 1'b1;
    push(12'h020, 1'b1, 3'd1, 1'b0);
    do_tick();
    start = 1'b0;
    ramp_steps(12'h020, 12'h060);

    // Clamp high to 0x1FF, back down, retarget down, clamp low, up to 0x40
    retarget(12'hFFF, 12'h060, 12'h1FF);
    retarget(12'h060, 12'h1FF, 12'h060);
    retarget(12'h04C, 12'h060, 12'h04C);
    retarget(12'h005, 12'h04C, 12'h020);
    retarget(12'h040, 12'h020, 12'h040);

    // Soft stop from 0x40
    repeat (2) @(posedge clk);
    #1 stop = 1'b1;
    push(12'h040, 1'b1, 3'd3, 1'b0);
    push(12'h038, 1'b1, 3'd3, 1'b0);
    push(12'h030, 1'b1, 3'd3, 1'b0);
    push(12'h028, 1'b1, 3'd3, 1'b0);
    push(12'h020, 1'b1, 3'd3, 1'b0);
    push(12'h000, 1'b0, 3'd0, 1'b0);
    ticks(17);
    stop = 1'b0;
    ticks(2);

    // Fault mid-ramp between ticks
    tgt_cmd = 12'h060;
    start   = 1'b1;
    push(12'h020, 1'b1, 3'd1, 1'b0);
    do_tick();
    start = 1'b0;
    push(12'h028, 1'b1, 3'd1, 1'b0);
    ticks(5);
    repeat (2) @(posedge clk);
    #1 fault = 1'b1;
    push(12'h000, 1'b0, 3'd4, 1'b0);
    @(posedge clk); #1;
    chk("fault_en_1clk", {31'd0, dut_en}, 32'd0);
    chk("fault_len_1clk", {20'd0, dut_len}, 32'd0);
    chk("fault_state_1clk", {29'd0, dut_state}, 32'd4);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fault_hold_after_deassert", {29'd0, dut_state}, 32'd4);
    push(12'h000, 1'b0, 3'd0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    ticks(1);

    // Tick, fault and stop together during RAMP
    start = 1'b1;
    push(12'h020, 1'b1, 3'd1, 1'b0);
    do_tick();
    start = 1'b0;
    tick  = 1'b1;
    fault = 1'b1;
    stop  = 1'b1;
    push(12'h000, 1'b0, 3'd4, 1'b0);
    @(posedge clk); #1;
    tick = 1'b0;
    chk("tick_fault_stop_state", {29'd0, dut_state}, 32'd4);
    fault = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
    push(12'h000, 1'b0, 3'd0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    ticks(1);

    // Async reset mid-RUN
    tgt_cmd = 12'h028;
    start   = 1'b1;
    push(12'h020, 1'b1, 3'd1, 1'b0);
    do_tick();
    start = 1'b0;
    push(12'h028, 1'b1, 3'd2, 1'b1);
    ticks(4);
    push(12'h000, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #3 nRst = 1'b0;
    #1;
    chk("rst_len", {20'd0, dut_len}, 32'd0);
    chk("rst_en", {31'd0, dut_en}, 32'd0);
    chk("rst_state", {29'd0, dut_state}, 32'd0);
    chk("rst_at", {31'd0, dut_at}, 32'd0);
    chk("rst_mask", {20'd0, dut_mask}, 32'h20);
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event got none want len=%h en=%b st=%0d at=%b",
               e.len, e.en, e.st, e.at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
